// File: rtl/axi_mem_slave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_mem_slave_pkg : response codes and FSM encodings for axi_mem_slave   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package axi_mem_slave_pkg;

   localparam logic [1:0] C_RESP_OKAY   = 2'b00;
   localparam logic [1:0] C_RESP_SLVERR = 2'b10;

   localparam logic [1:0] WS_IDLE = 2'd0;
   localparam logic [1:0] WS_DATA = 2'd1;
   localparam logic [1:0] WS_RESP = 2'd2;

   localparam logic [1:0] RS_IDLE  = 2'd0;
   localparam logic [1:0] RS_FETCH = 2'd1;
   localparam logic [1:0] RS_DATA  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/axi_mem_slave_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_mem_slave_ram : simple dual-port RAM, byte-enable write, 1-cycle     |
// | registered read (read-before-write on same-address collision). Rev 1.0   |
// +--------------------------------------------------------------------------+
module axi_mem_slave_ram #(
   parameter int WORDS  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [3:0]        i_wr_be,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [31:0]       i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [31:0]       o_rd_data
);

   logic [31:0] r_mem [WORDS];
   logic [31:0] r_rd_data;

   // Contents are deliberately not reset so they survive RST.
   always_ff @(posedge CLK) begin
      for (int b = 0; b < 4; b++) begin
         if (i_wr_be[b]) begin
            r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rd_data <= 32'd0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/axi_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_mem_slave : AXI4 INCR-burst memory slave, independent R/W channels.  |
// | Define AXI_MEM_SLAVE_ERRRESP_EN for range/WLAST checking with SLVERR.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module axi_mem_slave
   import axi_mem_slave_pkg::*;
#(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int MEM_WORDS          = 1024
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [7:0]                    S_AXI_AWLEN,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [31:0]                   S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WLAST,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [7:0]                    S_AXI_ARLEN,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [31:0]                   S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RLAST,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int WA = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [WA-1:0] C_WORD_INC = WA'(1);

   // ---------------- write channel ----------------
   logic [1:0]    r_ws;
   logic          r_awready, r_wready, r_bvalid, r_werr;
   logic [1:0]    r_bresp;
   logic [WA-1:0] r_waddr;
   logic [7:0]    r_wlen, r_wcnt;
   logic          w_wbeat, w_wlast_beat, w_woob, w_wbeat_err;
   logic [3:0]    w_wr_be;

   assign w_wbeat      = S_AXI_WVALID & r_wready;
   assign w_wlast_beat = (r_wcnt == r_wlen);

`ifdef AXI_MEM_SLAVE_ERRRESP_EN
   assign w_woob      = |r_waddr[WA-1:AW];
   assign w_wbeat_err = w_woob | (S_AXI_WLAST != w_wlast_beat);
`else
   assign w_woob      = 1'b0;
   assign w_wbeat_err = 1'b0;
`endif

   assign w_wr_be = w_wbeat ? (S_AXI_WSTRB & {4{~w_woob}}) : 4'b0000;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ws      <= WS_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= C_RESP_OKAY;
         r_waddr   <= '0;
         r_wlen    <= 8'd0;
         r_wcnt    <= 8'd0;
         r_werr    <= 1'b0;
      end else begin
         case (r_ws)
            WS_IDLE: begin
               if (S_AXI_AWVALID && r_awready) begin
                  r_waddr   <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                  r_wlen    <= S_AXI_AWLEN;
                  r_wcnt    <= 8'd0;
                  r_werr    <= 1'b0;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_ws      <= WS_DATA;
               end else begin
                  r_awready <= 1'b1;
               end
            end
            WS_DATA: begin
               if (w_wbeat) begin
                  r_waddr <= r_waddr + C_WORD_INC;
                  r_wcnt  <= r_wcnt + 8'd1;
                  r_werr  <= r_werr | w_wbeat_err;
                  if (w_wlast_beat) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bresp  <= (r_werr | w_wbeat_err) ? C_RESP_SLVERR : C_RESP_OKAY;
                     r_ws     <= WS_RESP;
                  end
               end
            end
            WS_RESP: begin
               if (S_AXI_BREADY) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_ws      <= WS_IDLE;
               end
            end
            default: r_ws <= WS_IDLE;
         endcase
      end
   end

   // ---------------- read channel ----------------
   logic [1:0]    r_rs;
   logic          r_arready, r_rvalid, r_rlast, r_rerr;
   logic [1:0]    r_rresp;
   logic [WA-1:0] r_raddr;
   logic [7:0]    r_rlen, r_rcnt;
   logic          w_roob;
   logic [31:0]   w_ram_rdata;

`ifdef AXI_MEM_SLAVE_ERRRESP_EN
   assign w_roob = |r_raddr[WA-1:AW];
`else
   assign w_roob = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rs      <= RS_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rerr    <= 1'b0;
         r_rresp   <= C_RESP_OKAY;
         r_raddr   <= '0;
         r_rlen    <= 8'd0;
         r_rcnt    <= 8'd0;
      end else begin
         case (r_rs)
            RS_IDLE: begin
               if (S_AXI_ARVALID && r_arready) begin
                  r_raddr   <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
                  r_rlen    <= S_AXI_ARLEN;
                  r_rcnt    <= 8'd0;
                  r_arready <= 1'b0;
                  r_rs      <= RS_FETCH;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            RS_FETCH: begin
               r_rvalid <= 1'b1;
               r_rlast  <= (r_rcnt == r_rlen);
               r_rerr   <= w_roob;
               r_rresp  <= w_roob ? C_RESP_SLVERR : C_RESP_OKAY;
               r_raddr  <= r_raddr + C_WORD_INC;
               r_rcnt   <= r_rcnt + 8'd1;
               r_rs     <= RS_DATA;
            end
            RS_DATA: begin
               if (S_AXI_RREADY) begin
                  r_rvalid <= 1'b0;
                  r_rlast  <= 1'b0;
                  if (r_rlast) begin
                     r_arready <= 1'b1;
                     r_rs      <= RS_IDLE;
                  end else begin
                     r_rs <= RS_FETCH;
                  end
               end
            end
            default: r_rs <= RS_IDLE;
         endcase
      end
   end

   // RAM output only changes in RS_FETCH, so RDATA holds while stalled.
   axi_mem_slave_ram #(
      .WORDS  (MEM_WORDS),
      .ADDR_W (AW)
   ) u_ram (
      .CLK       (CLK),
      .RST       (RST),
      .i_wr_be   (w_wr_be),
      .i_wr_addr (r_waddr[AW-1:0]),
      .i_wr_data (S_AXI_WDATA),
      .i_rd_en   (r_rs == RS_FETCH),
      .i_rd_addr (r_raddr[AW-1:0]),
      .o_rd_data (w_ram_rdata)
   );

   logic w_unused;
   assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WLAST,
                       r_waddr[WA-1:AW], r_raddr[WA-1:AW]};

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RLAST   = r_rlast;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = r_rerr ? 32'd0 : w_ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_mem_slave : directed table-driven bench for axi_mem_slave         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_axi_mem_slave;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0, S_AXI_WDATA = '0;
   logic [7:0]  S_AXI_AWLEN = '0, S_AXI_ARLEN = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_AWVALID = 0, S_AXI_WLAST = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
   logic        S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
   logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY;
   logic        S_AXI_RLAST, S_AXI_RVALID;
   logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
   logic [31:0] S_AXI_RDATA;

   always #5 CLK = ~CLK;

   axi_mem_slave dut (
      .CLK(CLK), .RST(RST),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
   );

`ifdef AXI_MEM_SLAVE_ERRRESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] wr_data [16];
   logic [31:0] rd_data [16];
   logic        rd_last [16];
   logic [1:0]  rd_resp [16];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;
   vec_t vt [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for DUT", nm);
   endtask

   task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] strb,
                            input int bdelay, input bit bad_last, input logic [1:0] exp_resp,
                            input string nm);
      int n;
      @(negedge CLK);
      S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len); S_AXI_AWVALID = 1'b1;
      n = 0;
      while (!S_AXI_AWREADY && n < 20) begin @(negedge CLK); n++; end
      if (n >= 20) tmo({nm, " aw"});
      @(negedge CLK);
      S_AXI_AWVALID = 1'b0;
      for (int b = 0; b <= len; b++) begin
         S_AXI_WDATA = wr_data[b]; S_AXI_WSTRB = strb;
         S_AXI_WLAST = (b == len) && !bad_last; S_AXI_WVALID = 1'b1;
         n = 0;
         while (!S_AXI_WREADY && n < 20) begin @(negedge CLK); n++; end
         if (n >= 20) tmo({nm, " w"});
         @(negedge CLK);
      end
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
      chk({nm, " bvalid"}, 32'(S_AXI_BVALID), 32'd1);
      chk({nm, " bresp"}, 32'(S_AXI_BRESP), 32'(exp_resp));
      for (int i = 0; i < bdelay; i++) begin
         @(negedge CLK);
         chk({nm, " bvalid hold"}, 32'(S_AXI_BVALID), 32'd1);
         chk({nm, " bresp hold"}, 32'(S_AXI_BRESP), 32'(exp_resp));
         chk({nm, " awready low"}, 32'(S_AXI_AWREADY), 32'd0);
      end
      S_AXI_BREADY = 1'b1;
      @(negedge CLK);
      S_AXI_BREADY = 1'b0;
      chk({nm, " bvalid drop"}, 32'(S_AXI_BVALID), 32'd0);
      chk({nm, " awready back"}, 32'(S_AXI_AWREADY), 32'd1);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int len, input bit stall, input string nm);
      int n;
      logic [31:0] hold;
      @(negedge CLK);
      S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARVALID = 1'b1;
      n = 0;
      while (!S_AXI_ARREADY && n < 20) begin @(negedge CLK); n++; end
      if (n >= 20) tmo({nm, " ar"});
      @(negedge CLK);
      S_AXI_ARVALID = 1'b0;
      chk({nm, " rvalid fetch"}, 32'(S_AXI_RVALID), 32'd0);
      for (int b = 0; b <= len; b++) begin
         n = 0;
         while (!S_AXI_RVALID && n < 20) begin @(negedge CLK); n++; end
         if (n >= 20) tmo({nm, " r"});
         chk({nm, " r latency"}, n, 1);
         if (stall && (b % 2 == 0)) begin
            hold = S_AXI_RDATA;
            @(negedge CLK);
            chk({nm, " rvalid stall"}, 32'(S_AXI_RVALID), 32'd1);
            chk({nm, " rdata stall"}, S_AXI_RDATA, hold);
         end
         rd_data[b] = S_AXI_RDATA; rd_last[b] = S_AXI_RLAST; rd_resp[b] = S_AXI_RRESP;
         S_AXI_RREADY = 1'b1;
         @(negedge CLK);
         S_AXI_RREADY = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0};
      vt[1]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF};
      vt[2]  = '{1'b1, 32'h20,  32'h11223344, 4'b1111, 32'h0};
      vt[3]  = '{1'b1, 32'h20,  32'h00AA0000, 4'b0100, 32'h0};
      vt[4]  = '{1'b0, 32'h20,  32'h0,        4'b0000, 32'h11AA3344};
      vt[5]  = '{1'b1, 32'h24,  32'hCAFEF00D, 4'b1111, 32'h0};
      vt[6]  = '{1'b1, 32'h24,  32'hFFFFFFFF, 4'b0000, 32'h0};
      vt[7]  = '{1'b0, 32'h24,  32'h0,        4'b0000, 32'hCAFEF00D};
      vt[8]  = '{1'b1, 32'h28,  32'hA5A5A5A5, 4'b1111, 32'h0};
      vt[9]  = '{1'b1, 32'h28,  32'h00000012, 4'b0001, 32'h0};
      vt[10] = '{1'b1, 32'h28,  32'h34000000, 4'b1000, 32'h0};
      vt[11] = '{1'b0, 32'h28,  32'h0,        4'b0000, 32'h34A5A512};
      vt[12] = '{1'b1, 32'hFFC, 32'h0BADF00D, 4'b1111, 32'h0};
      vt[13] = '{1'b0, 32'hFFC, 32'h0,        4'b0000, 32'h0BADF00D};

      repeat (3) @(negedge CLK);
      chk("rst awready", 32'(S_AXI_AWREADY), 0);
      chk("rst wready",  32'(S_AXI_WREADY), 0);
      chk("rst bvalid",  32'(S_AXI_BVALID), 0);
      chk("rst arready", 32'(S_AXI_ARREADY), 0);
      chk("rst rvalid",  32'(S_AXI_RVALID), 0);
      chk("rst rlast",   32'(S_AXI_RLAST), 0);
      chk("rst resp",    32'({S_AXI_BRESP, S_AXI_RRESP}), 0);
      chk("rst rdata",   S_AXI_RDATA, 0);
      RST = 1'b0;
      @(negedge CLK);
      chk("release awready", 32'(S_AXI_AWREADY), 1);
      chk("release arready", 32'(S_AXI_ARREADY), 1);

      for (int i = 0; i < 14; i++) begin
         if (vt[i].wr) begin
            wr_data[0] = vt[i].data;
            axi_write(vt[i].addr, 0, vt[i].strb, 0, 1'b0, 2'b00, $sformatf("vec%0d wr", i));
         end else begin
            axi_read(vt[i].addr, 0, 1'b0, $sformatf("vec%0d rd", i));
            chk($sformatf("vec%0d rdata", i), rd_data[0], vt[i].exp);
            chk($sformatf("vec%0d rlast", i), 32'(rd_last[0]), 1);
            chk($sformatf("vec%0d rresp", i), 32'(rd_resp[0]), 0);
         end
      end

      // 4-beat burst, read back with RREADY stalls
      for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
      axi_write(32'h40, 3, 4'b1111, 0, 1'b0, 2'b00, "burst wr");
      axi_read(32'h40, 3, 1'b1, "burst rd");
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("burst rdata%0d", i), rd_data[i], 32'(i + 1));
         chk($sformatf("burst rlast%0d", i), 32'(rd_last[i]), 32'(i == 3));
      end

      // B channel back-pressure
      wr_data[0] = 32'h5555AAAA;
      axi_write(32'h50, 0, 4'b1111, 5, 1'b0, 2'b00, "bstall");
      axi_read(32'h50, 0, 1'b0, "bstall rd");
      chk("bstall rdata", rd_data[0], 32'h5555AAAA);

      // WLAST missing on final beat
      wr_data[0] = 32'h101; wr_data[1] = 32'h202;
      axi_write(32'h80, 1, 4'b1111, 0, 1'b1, ERR_EN ? 2'b10 : 2'b00, "wlast");

      // Address at MEM_WORDS*4
      wr_data[0] = 32'h01234567;
      axi_write(32'h0, 0, 4'b1111, 0, 1'b0, 2'b00, "word0 wr");
      wr_data[0] = 32'h77777777;
      axi_write(32'h1000, 0, 4'b1111, 0, 1'b0, ERR_EN ? 2'b10 : 2'b00, "oob wr");
      axi_read(32'h0, 0, 1'b0, "word0 rd");
      chk("word0 rdata", rd_data[0], ERR_EN ? 32'h01234567 : 32'h77777777);
      axi_read(32'h1000, 0, 1'b0, "oob rd");
      chk("oob rdata", rd_data[0], ERR_EN ? 32'h0 : 32'h77777777);
      chk("oob rresp", 32'(rd_resp[0]), ERR_EN ? 32'd2 : 32'd0);

      // Reset during the third beat of a 4-beat read
      @(negedge CLK);
      S_AXI_ARADDR = 32'h40; S_AXI_ARLEN = 8'd3; S_AXI_ARVALID = 1'b1;
      n = 0;
      while (!S_AXI_ARREADY && n < 20) begin @(negedge CLK); n++; end
      @(negedge CLK);
      S_AXI_ARVALID = 1'b0;
      for (int b = 0; b < 3; b++) begin
         n = 0;
         while (!S_AXI_RVALID && n < 20) begin @(negedge CLK); n++; end
         if (n >= 20) tmo("rstmid r");
         if (b < 2) begin
            S_AXI_RREADY = 1'b1;
            @(negedge CLK);
            S_AXI_RREADY = 1'b0;
         end
      end
      chk("rstmid beat3 data", S_AXI_RDATA, 32'd3);
      RST = 1'b1;
      @(negedge CLK);
      chk("rstmid rvalid", 32'(S_AXI_RVALID), 0);
      chk("rstmid rdata", S_AXI_RDATA, 0);
      chk("rstmid arready", 32'(S_AXI_ARREADY), 0);
      RST = 1'b0;
      @(negedge CLK);
      chk("rstmid arready after", 32'(S_AXI_ARREADY), 1);
      chk("rstmid rvalid after", 32'(S_AXI_RVALID), 0);
      axi_read(32'h40, 3, 1'b0, "post rst rd");
      for (int i = 0; i < 4; i++)
         chk($sformatf("post rst rdata%0d", i), rd_data[i], 32'(i + 1));
      axi_read(32'h10, 0, 1'b0, "post rst rd10");
      chk("post rst rdata10", rd_data[0], 32'hDEADBEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
